// File: rtl/uart_tx_arb_if.sv
// Two-requester byte handshake bundle feeding the arbitrated UART transmitter.
// The master side offers bytes; the slave side (the transmitter) returns ready.
interface uart_tx_arb_if;
   logic       req0_valid;
   logic [7:0] req0_data;
   logic       req0_ready;
   logic       req1_valid;
   logic [7:0] req1_data;
   logic       req1_ready;

   modport master (
      output req0_valid,
      output req0_data,
      output req1_valid,
      output req1_data,
      input  req0_ready,
      input  req1_ready
   );

   modport slave (
      input  req0_valid,
      input  req0_data,
      input  req1_valid,
      input  req1_data,
      output req0_ready,
      output req1_ready
   );
endinterface

// File: rtl/uart_tx_arb.sv
// 8N1 UART transmitter shared by two requesters with round-robin arbitration.
// A byte is accepted only while the line is idle; each bit lasts DIV clocks.
module uart_tx_arb #(
   parameter int unsigned DIV = 2604
) (
   input  logic         clk,
   input  logic         reset,
   uart_tx_arb_if.slave req,
   output logic         txd,
   output logic         busy,
   output logic         grant_id
);

   typedef enum logic [1:0] {
      StIdle,
      StStart,
      StData,
      StStop
   } state_e;

   localparam logic [11:0] BitLast = 12'(DIV - 1);

   state_e      state_q;
   logic [11:0] cnt_q;
   logic [2:0]  bit_idx_q;
   logic [7:0]  shreg_q;
   logic        last_grant_q;

   logic sel;
   logic any_valid;
   logic can_accept;
   logic hs;
   logic bit_end;

   // Contested requests go to whichever requester was not served last.
   always_comb begin
      sel       = 1'b0;
      any_valid = 1'b0;
      if (req.req0_valid && req.req1_valid) begin
         any_valid = 1'b1;
         sel       = ~last_grant_q;
      end else if (req.req0_valid) begin
         any_valid = 1'b1;
         sel       = 1'b0;
      end else if (req.req1_valid) begin
         any_valid = 1'b1;
         sel       = 1'b1;
      end
   end

   assign can_accept     = (state_q == StIdle) && !reset;
   assign req.req0_ready = can_accept && any_valid && !sel;
   assign req.req1_ready = can_accept && any_valid && sel;
   assign hs             = req.req0_ready || req.req1_ready;
   assign busy           = (state_q != StIdle);
   assign bit_end        = (cnt_q == BitLast);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         txd          <= 1'b1;
         grant_id     <= 1'b0;
         last_grant_q <= 1'b1;
         cnt_q        <= '0;
         bit_idx_q    <= '0;
         shreg_q      <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               txd       <= 1'b1;
               cnt_q     <= '0;
               bit_idx_q <= '0;
               if (hs) begin
                  shreg_q      <= sel ? req.req1_data : req.req0_data;
                  grant_id     <= sel;
                  last_grant_q <= sel;
                  txd          <= 1'b0;
                  state_q      <= StStart;
               end
            end
            StStart: begin
               if (bit_end) begin
                  cnt_q   <= '0;
                  txd     <= shreg_q[0];
                  shreg_q <= {1'b0, shreg_q[7:1]};
                  state_q <= StData;
               end else begin
                  cnt_q <= cnt_q + 12'd1;
               end
            end
            StData: begin
               if (bit_end) begin
                  cnt_q <= '0;
                  if (bit_idx_q == 3'd7) begin
                     txd     <= 1'b1;
                     state_q <= StStop;
                  end else begin
                     bit_idx_q <= bit_idx_q + 3'd1;
                     txd       <= shreg_q[0];
                     shreg_q   <= {1'b0, shreg_q[7:1]};
                  end
               end else begin
                  cnt_q <= cnt_q + 12'd1;
               end
            end
            StStop: begin
               if (bit_end) begin
                  cnt_q   <= '0;
                  state_q <= StIdle;
               end else begin
                  cnt_q <= cnt_q + 12'd1;
               end
            end
            default: begin
               state_q <= StIdle;
               txd     <= 1'b1;
            end
         endcase
      end
   end

endmodule
